// File: rtl/instruction_mem.sv
// Instruction register plus execute stage for the 8-bit CPU.
// Stage p1 holds the latched instruction {opcode, a, b} and produces the
// combinational ALU result from it. Stage p2 holds the write-back copy of
// that result.
module instruction_mem (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opcode,
  output logic [2:0] alu_sel,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic [7:0] data_out
);

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_DIV = 3'b110;
  localparam logic [OP_W-1:0] OP_CMP = 3'b111;

  // Unsigned ALU. The returned vector is {flag, result}; the flag is the
  // carry for ADD, the borrow for SUB, the overflow for MUL and the
  // divide-by-zero error for DIV. It is zero for all other operations.
  function automatic logic [DATA_W:0] alu_eval(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     res;
    sum  = {1'b0, x} + {1'b0, y};
    prod = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
    res  = '0;
    case (op)
      OP_ADD: res = sum;
      OP_SUB: res = {(x < y), x - y};
      OP_AND: res = {1'b0, x & y};
      OP_OR:  res = {1'b0, x | y};
      OP_XOR: res = {1'b0, x ^ y};
      // Any set bit in the upper byte means the product does not fit.
      OP_MUL: res = {(prod[2*DATA_W-1:DATA_W] != '0), prod[DATA_W-1:0]};
      // Division by zero saturates the quotient and raises the error flag.
      OP_DIV: res = (y == '0) ? {1'b1, {DATA_W{1'b1}}} : {1'b0, x / y};
      // One-hot compare: bit2 less-than, bit1 equal, bit0 greater-than.
      OP_CMP: res = {1'b0, 5'b0, (x < y), (x == y), (x > y)};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [OP_W-1:0]   r_op_p1;
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [DATA_W:0]   w_res_p1;
  logic [DATA_W-1:0] r_data_p2;

  // ---- stage p1: instruction register, loaded every cycle out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_p1 <= '0;
      r_a_p1  <= '0;
      r_b_p1  <= '0;
    end else begin
      r_op_p1 <= opcode;
      r_a_p1  <= a;
      r_b_p1  <= b;
    end
  end

  // Execute the registered instruction; never looks at the live inputs.
  always_comb begin
    w_res_p1 = alu_eval(r_op_p1, r_a_p1, r_b_p1);
  end

  // ---- stage p2: write-back copy of the ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p2 <= '0;
    end else begin
      r_data_p2 <= w_res_p1[DATA_W-1:0];
    end
  end

  assign alu_sel   = r_op_p1;
  assign alu_out   = w_res_p1[DATA_W-1:0];
  assign carry_out = w_res_p1[DATA_W];
  assign data_out  = r_data_p2;

endmodule

// File: tb/tb_instruction_mem.sv
// Bench for instruction_mem: directed vectors with literal expectations,
// plus a reference model checked against the DUT on every falling edge.
module tb_instruction_mem;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [7:0] data_out;

  int checks;
  int failures;

  instruction_mem dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the execute stage must show for a given instruction,
  // worked out with integer arithmetic straight from the operation table.
  function automatic logic [8:0] model_alu(input int op, input int x, input int y);
    int r;
    int f;
    r = 0;
    f = 0;
    case (op)
      0: begin r = (x + y) % 256; f = (x + y > 255) ? 1 : 0; end
      1: begin r = (x - y + 256) % 256; f = (x < y) ? 1 : 0; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = (x * y) % 256; f = (x * y > 255) ? 1 : 0; end
      6: begin
        if (y == 0) begin r = 255; f = 1; end
        else r = x / y;
      end
      default: begin
        if (x < y) r = 4;
        else if (x == y) r = 2;
        else r = 1;
      end
    endcase
    return {f[0], r[7:0]};
  endfunction

  // Model state: the instruction held by the DUT and the write-back value.
  int         m_op, m_a, m_b;
  logic [7:0] m_data;
  bit         m_valid;

  always @(posedge clk) begin
    logic [8:0] cur;
    if (rst) begin
      m_op = 0; m_a = 0; m_b = 0;
      m_data = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      cur = model_alu(m_op, m_a, m_b);
      m_data = cur[7:0];
      m_op = int'(opcode);
      m_a = int'(a);
      m_b = int'(b);
    end
  end

  // Compare process: away from the active edge, every cycle after reset.
  always @(negedge clk) begin
    logic [8:0] e;
    if (m_valid) begin
      e = model_alu(m_op, m_a, m_b);
      checks++;
      if (alu_sel !== m_op[2:0] || alu_out !== e[7:0] || carry_out !== e[8] ||
          data_out !== m_data) begin
        failures++;
        $display("FAIL model t=%0t sel=%h out=%h c=%b data=%h required sel=%h out=%h c=%b data=%h",
                 $time, alu_sel, alu_out, carry_out, data_out, m_op[2:0], e[7:0], e[8], m_data);
      end
    end
  end

  logic [7:0] prev_exp;

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one instruction, step one edge, check literal result and the
  // write-back of the previous instruction.
  task automatic apply(input string name, input logic [2:0] op, input logic [7:0] xa,
                       input logic [7:0] xb, input logic [7:0] exp_out, input logic exp_c);
    opcode = op; a = xa; b = xb;
    @(posedge clk); #1;
    check_lit({name, "_sel"}, {5'b0, alu_sel}, {5'b0, op});
    check_lit({name, "_out"}, alu_out, exp_out);
    check_lit({name, "_carry"}, {7'b0, carry_out}, {7'b0, exp_c});
    check_lit({name, "_data"}, data_out, prev_exp);
    prev_exp = exp_out;
  endtask

  task automatic check_zero(input string name);
    check_lit({name, "_sel"}, {5'b0, alu_sel}, 8'h00);
    check_lit({name, "_out"}, alu_out, 8'h00);
    check_lit({name, "_carry"}, {7'b0, carry_out}, 8'h00);
    check_lit({name, "_data"}, data_out, 8'h00);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_valid = 1'b0;
    m_op = 0; m_a = 0; m_b = 0; m_data = 8'h00;
    rst = 1'b1;
    a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
    @(posedge clk); #1;
    a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
    @(posedge clk); #1;
    check_zero("reset");

    // Model self-pins against hand-computed values.
    check_lit("model_mul", model_alu(5, 8'hCC, 8'hAA) & 9'h0FF, 8'h78);
    check_lit("model_div0", {7'b0, model_alu(6, 5, 0) >> 8}, 8'h01);

    rst = 1'b0;
    prev_exp = 8'h00;
    apply("add", 3'b000, 8'h05, 8'h03, 8'h08, 1'b0);
    apply("add_ovf", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
    apply("sub", 3'b001, 8'hCC, 8'hAA, 8'h22, 1'b0);
    apply("sub_brw", 3'b001, 8'h03, 8'h05, 8'hFE, 1'b1);
    apply("and", 3'b010, 8'h05, 8'h03, 8'h01, 1'b0);
    apply("or", 3'b011, 8'hCC, 8'hAA, 8'hEE, 1'b0);
    apply("xor", 3'b100, 8'h05, 8'h03, 8'h06, 1'b0);
    apply("mul_ovf", 3'b101, 8'hCC, 8'hAA, 8'h78, 1'b1);
    apply("mul", 3'b101, 8'h05, 8'h03, 8'h0F, 1'b0);
    apply("div", 3'b110, 8'h05, 8'h03, 8'h01, 1'b0);
    apply("div0", 3'b110, 8'h05, 8'h00, 8'hFF, 1'b1);
    apply("cmp_gt", 3'b111, 8'hCC, 8'hAA, 8'h01, 1'b0);
    apply("cmp_eq", 3'b111, 8'h05, 8'h05, 8'h02, 1'b0);
    apply("cmp_lt", 3'b111, 8'h03, 8'h05, 8'h04, 1'b0);

    // Mid-stream reset discards the in-flight instruction.
    apply("pre_rst", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
    rst = 1'b1;
    opcode = 3'b101; a = 8'hCC; b = 8'hAA;
    @(posedge clk); #1;
    check_zero("mid_reset");
    rst = 1'b0;
    prev_exp = 8'h00;

    // Back-to-back sweep of all eight operations.
    apply("b2b_add", 3'b000, 8'h80, 8'h80, 8'h00, 1'b1);
    apply("b2b_sub", 3'b001, 8'h10, 8'h01, 8'h0F, 1'b0);
    apply("b2b_and", 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0);
    apply("b2b_or", 3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0);
    apply("b2b_xor", 3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    apply("b2b_mul", 3'b101, 8'h10, 8'h10, 8'h00, 1'b1);
    apply("b2b_div", 3'b110, 8'hFF, 8'h10, 8'h0F, 1'b0);
    apply("b2b_cmp", 3'b111, 8'h00, 8'hFF, 8'h04, 1'b0);

    // Random stream checked by the model only.
    for (int i = 0; i < 40; i++) begin
      opcode = 3'($urandom); a = 8'($urandom); b = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      @(posedge clk); #1;
    end
    opcode = 3'b000; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
